bp_fe_bht_gshare: RTL and testbench
===================================

BP_FE_BHT_GSHARE -- requirements
Module: bp_fe_bht_gshare

Interface
REQ-001 bht_idx_width_p, 6, log2 of table entries (els = 2**bht_idx_width_p).
REQ-002 ghist_width_p, 4, global history length, SHALL satisfy 1 <= ghist_width_p <= bht_idx_width_p.
REQ-003 ctr_width_p, 2, saturating counter width, SHALL be >= 2.
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 reset_i  in  1  reset, asynchronous and active-low.
REQ-006 ready_o  out  1  table initialised; reads and writes accepted only when high.
REQ-007 r_v_i  in  1  prediction lookup request.
REQ-008 idx_r_i  in  bht_idx_width_p  PC-derived lookup index.
REQ-009 predict_v_o  out  1  prediction valid, one cycle after an accepted lookup.
REQ-010 predict_taken_o  out  1  predicted direction (counter MSB).
REQ-011 predict_ghist_o  out  ghist_width_p  speculative history used for this lookup, returned later with the update.
REQ-012 spec_v_i  in  1  speculatively shift spec_taken_i into the history.
REQ-013 spec_taken_i  in  1  speculative direction.
REQ-014 w_v_i  in  1  resolved-branch update.
REQ-015 idx_w_i  in  bht_idx_width_p  PC-derived index of the resolved branch.
REQ-016 w_ghist_i  in  ghist_width_p  history snapshot captured at prediction.
REQ-017 w_taken_i  in  1  actual outcome.
REQ-018 w_mispredict_i  in  1  resolved direction differs from prediction; qualified by w_v_i.

Function
REQ-019 Table index SHALL be idx XOR zero-extended history, with history in the low ghist_width_p bits; reads use spec history, writes use w_ghist_i.
REQ-020 Lookup latency SHALL be one cycle; predict_v_o = registered (r_v_i & ready_o); predict_taken_o and predict_ghist_o SHALL be 0 when predict_v_o is 0.
REQ-021 On an accepted update, the counter SHALL increment if w_taken_i, otherwise decrement, saturating at 0 and 2**ctr_width_p-1.
REQ-022 A same-cycle read and write to the same entry SHALL return the pre-update counter value.
REQ-023 spec_v_i SHALL shift the spec history left by one, inserting spec_taken_i at bit 0.
REQ-024 On w_v_i & w_mispredict_i, spec history SHALL become {w_ghist_i[ghist_width_p-2:0], w_taken_i}; this restore SHALL take priority over a same-cycle spec_v_i.
REQ-025 The lookup in the same cycle as a shift or restore SHALL use the pre-update history.
REQ-026 An init FSM SHALL have states INIT and READY; INIT writes the weak-not-taken value (2**(ctr_width_p-1)-1) to one entry per cycle, from index 0 to els-1, then moves to READY.
REQ-027 ready_o SHALL be high only in READY; INIT SHALL last exactly els cycles after reset release.
REQ-028 r_v_i, spec_v_i and w_v_i SHALL be ignored while ready_o is low.

Reset
REQ-029 Asserting reset_i SHALL immediately clear ready_o, predict_v_o, predict_taken_o, predict_ghist_o, spec history and the init pointer, and SHALL force INIT, including mid-init or mid-operation.
REQ-030 Table contents SHALL NOT be reset directly; the INIT sweep SHALL define them.

Structure
REQ-031 The FSM state enum and the weak-not-taken constant function SHALL live in bp_fe_pkg.
REQ-032 Counter next-state logic SHALL be the sub-module bp_fe_sat_counter (parameter ctr_width_p, inputs count and taken, output next count).
REQ-033 Table storage SHALL be a flop array with one read port and one write port; the INIT write SHALL share the write port.

Verification
REQ-034 Release reset, hold r_v_i=1 -> ready_o rises after exactly 64 cycles; predict_v_o=0 before that, then every lookup predicts not-taken with the counter at 01.
REQ-035 Five taken updates, idx_w_i=5, w_ghist_i=0 -> counter 01,10,11,11,11; a lookup with idx_r_i=5 and spec history 0 predicts taken.
REQ-036 Same-cycle read and write to entry 5 with counter 01 and w_taken_i=1 -> predict_taken_o=0; the next lookup gives 1.
REQ-037 Spec history 0000, spec_taken_i 1,1,0, then w_mispredict_i with w_ghist_i=0011 and w_taken_i=1 in the same cycle as spec_v_i -> history 0111; the next predict_ghist_o=0111.
REQ-038 Assert reset_i at INIT entry 30, release -> ready_o low, sweep restarts at 0 and completes 64 cycles later.
REQ-039 Update at idx_w_i=3 with w_ghist_i=0001 -> only entry 2 changes.

Source files
------------

// File: rtl/bp_fe_pkg.sv
// Shared types and constants for the front-end branch history table.
package bp_fe_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } bht_state_e;

  // Weakly not-taken: MSB clear, all lower bits set (01 for a 2-bit counter).
  function automatic int unsigned bp_fe_weak_nt(input int unsigned ctr_w);
    return (32'd1 << (ctr_w - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/bp_fe_sat_counter.sv
// Saturating up/down counter next-state logic for one BHT entry.
module bp_fe_sat_counter #(
  parameter int ctr_width_p = 2
) (
  input  logic [ctr_width_p-1:0] count_i,
  input  logic                   taken_i,
  output logic [ctr_width_p-1:0] count_o
);

  always_comb begin
    count_o = count_i;
    if (taken_i) begin
      if (count_i != '1) count_o = count_i + 1'b1;
    end else begin
      if (count_i != '0) count_o = count_i - 1'b1;
    end
  end

endmodule

// File: rtl/bp_fe_bht_gshare.sv
// Gshare branch history table: speculative global history XOR PC index into
// a table of saturating counters, swept to weak-not-taken after every reset.
module bp_fe_bht_gshare
  import bp_fe_pkg::*;
#(
  parameter int bht_idx_width_p = 6,
  parameter int ghist_width_p   = 4,
  parameter int ctr_width_p     = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  output logic                       ready_o,
  input  logic                       r_v_i,
  input  logic [bht_idx_width_p-1:0] idx_r_i,
  output logic                       predict_v_o,
  output logic                       predict_taken_o,
  output logic [ghist_width_p-1:0]   predict_ghist_o,
  input  logic                       spec_v_i,
  input  logic                       spec_taken_i,
  input  logic                       w_v_i,
  input  logic [bht_idx_width_p-1:0] idx_w_i,
  input  logic [ghist_width_p-1:0]   w_ghist_i,
  input  logic                       w_taken_i,
  input  logic                       w_mispredict_i
);

  localparam int els_lp = 1 << bht_idx_width_p;
  localparam logic [ctr_width_p-1:0] weak_nt_lp = ctr_width_p'(bp_fe_weak_nt(ctr_width_p));

  bht_state_e                 r_state, w_state_n;
  logic [bht_idx_width_p-1:0] r_init_ptr;
  logic [ctr_width_p-1:0]     r_tbl [els_lp];
  logic [ghist_width_p-1:0]   r_spec_hist;
  logic                       r_pred_v, r_pred_taken;
  logic [ghist_width_p-1:0]   r_pred_ghist;

  logic                       w_init, w_ready, w_rd, w_upd, w_we;
  logic [bht_idx_width_p-1:0] w_ridx, w_uidx, w_widx;
  logic [ctr_width_p-1:0]     w_ctr_next, w_wdata;
  logic [ghist_width_p-1:0]   w_shift_hist, w_restore_hist;

  // ---------------- init FSM ----------------
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) r_state <= ST_INIT;
    else          r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_INIT:  if (r_init_ptr == '1) w_state_n = ST_READY;
      ST_READY: w_state_n = ST_READY;
      default:  w_state_n = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)    r_init_ptr <= '0;
    else if (w_init) r_init_ptr <= r_init_ptr + 1'b1;
  end

  assign w_init  = (r_state == ST_INIT);
  assign w_ready = (r_state == ST_READY);
  assign ready_o = w_ready;

  // ---------------- table ----------------
  assign w_rd   = r_v_i & w_ready;
  assign w_upd  = w_v_i & w_ready;
  assign w_ridx = idx_r_i ^ bht_idx_width_p'(r_spec_hist);
  assign w_uidx = idx_w_i ^ bht_idx_width_p'(w_ghist_i);

  bp_fe_sat_counter #(.ctr_width_p(ctr_width_p)) u_ctr (
    .count_i (r_tbl[w_uidx]),
    .taken_i (w_taken_i),
    .count_o (w_ctr_next)
  );

  // The init sweep owns the single write port until READY.
  assign w_we    = w_init | w_upd;
  assign w_widx  = w_init ? r_init_ptr : w_uidx;
  assign w_wdata = w_init ? weak_nt_lp : w_ctr_next;

  always_ff @(posedge clk_i) begin
    if (w_we) r_tbl[w_widx] <= w_wdata;
  end

  // Read samples the array before this edge's write lands: read-old-data.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_pred_v     <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_ghist <= '0;
    end else begin
      r_pred_v     <= w_rd;
      r_pred_taken <= w_rd ? r_tbl[w_ridx][ctr_width_p-1] : 1'b0;
      r_pred_ghist <= w_rd ? r_spec_hist : '0;
    end
  end

  assign predict_v_o     = r_pred_v;
  assign predict_taken_o = r_pred_taken;
  assign predict_ghist_o = r_pred_ghist;

  // ---------------- speculative history ----------------
  if (ghist_width_p == 1) begin : g_hist1
    assign w_shift_hist   = spec_taken_i;
    assign w_restore_hist = w_taken_i;
  end else begin : g_histn
    assign w_shift_hist   = {r_spec_hist[ghist_width_p-2:0], spec_taken_i};
    assign w_restore_hist = {w_ghist_i[ghist_width_p-2:0], w_taken_i};
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)                   r_spec_hist <= '0;
    else if (w_upd & w_mispredict_i) r_spec_hist <= w_restore_hist;
    else if (spec_v_i & w_ready)    r_spec_hist <= w_shift_hist;
  end

endmodule

// File: tb/tb_bp_fe_bht_gshare.sv
// Scoreboard bench for bp_fe_bht_gshare: driver queues expected predictions,
// monitor pops and compares whenever predict_v_o is high.
module tb_bp_fe_bht_gshare;

  typedef struct {
    logic       t;
    logic [3:0] g;
  } exp_t;

  logic       clk;
  logic       reset_i;
  logic       ready_o;
  logic       r_v_i;
  logic [5:0] idx_r_i;
  logic       predict_v_o;
  logic       predict_taken_o;
  logic [3:0] predict_ghist_o;
  logic       spec_v_i;
  logic       spec_taken_i;
  logic       w_v_i;
  logic [5:0] idx_w_i;
  logic [3:0] w_ghist_i;
  logic       w_taken_i;
  logic       w_mispredict_i;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  bp_fe_bht_gshare #(
    .bht_idx_width_p (6),
    .ghist_width_p   (4),
    .ctr_width_p     (2)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .ready_o         (ready_o),
    .r_v_i           (r_v_i),
    .idx_r_i         (idx_r_i),
    .predict_v_o     (predict_v_o),
    .predict_taken_o (predict_taken_o),
    .predict_ghist_o (predict_ghist_o),
    .spec_v_i        (spec_v_i),
    .spec_taken_i    (spec_taken_i),
    .w_v_i           (w_v_i),
    .idx_w_i         (idx_w_i),
    .w_ghist_i       (w_ghist_i),
    .w_taken_i       (w_taken_i),
    .w_mispredict_i  (w_mispredict_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one sample per cycle, just after the rising edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    total++;
    if (predict_v_o === 1'b1) begin
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pred got v=1 t=%0b g=%b required no prediction",
                 predict_taken_o, predict_ghist_o);
      end else begin
        e = q.pop_front();
        if (predict_taken_o !== e.t || predict_ghist_o !== e.g) begin
          bad++;
          $display("FAIL pred got t=%0b g=%b required t=%0b g=%b",
                   predict_taken_o, predict_ghist_o, e.t, e.g);
        end
      end
    end else if (predict_v_o !== 1'b0 || predict_taken_o !== 1'b0 || predict_ghist_o !== 4'b0) begin
      bad++;
      $display("FAIL idle_zero got v=%b t=%b g=%b required all zero",
               predict_v_o, predict_taken_o, predict_ghist_o);
    end
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got %0h required %0h", n, got, exp);
    end
  endtask

  task automatic clear_inputs();
    r_v_i = 0; idx_r_i = '0; spec_v_i = 0; spec_taken_i = 0;
    w_v_i = 0; idx_w_i = '0; w_ghist_i = '0; w_taken_i = 0; w_mispredict_i = 0;
  endtask

  // One cycle of stimulus; a lookup queues its hand-computed prediction.
  task automatic step(input logic rv, input logic [5:0] ir, input logic sv, input logic st,
                      input logic wv, input logic [5:0] iw, input logic [3:0] wg,
                      input logic wt, input logic wm, input logic et, input logic [3:0] eg);
    exp_t e;
    r_v_i = rv; idx_r_i = ir; spec_v_i = sv; spec_taken_i = st;
    w_v_i = wv; idx_w_i = iw; w_ghist_i = wg; w_taken_i = wt; w_mispredict_i = wm;
    if (rv) begin
      e.t = et; e.g = eg;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  // Release reset with a lookup held high; ready must appear on the 64th edge.
  task automatic init_sweep(input logic noisy);
    exp_t e;
    clear_inputs();
    r_v_i = 1;
    if (noisy) begin
      spec_v_i = 1; spec_taken_i = 1;
      w_v_i = 1; idx_w_i = 6'd5; w_taken_i = 1; w_mispredict_i = 1;
    end
    reset_i = 1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      chk("init_ready", 32'(ready_o), 32'(k == 64));
    end
    spec_v_i = 0; w_v_i = 0; w_mispredict_i = 0;
    e.t = 0; e.g = 4'b0000;
    q.push_back(e);
    @(negedge clk);
    r_v_i = 0;
  endtask

  initial begin
    clear_inputs();
    reset_i = 1;
    #2 reset_i = 0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(ready_o), 0);
    chk("reset_pv", 32'(predict_v_o), 0);

    init_sweep(1'b0);

    // all entries weak-not-taken
    step(1, 6'd0,  0,0, 0,0,4'd0,0,0, 0,4'b0000);
    step(1, 6'd17, 0,0, 0,0,4'd0,0,0, 0,4'b0000);
    step(1, 6'd63, 0,0, 0,0,4'd0,0,0, 0,4'b0000);

    // entry 5: same-cycle lookup sees the pre-update counter 01,10,11,11,11
    step(1, 6'd5, 0,0, 1,6'd5,4'd0,1,0, 0,4'b0000);
    repeat (4) step(1, 6'd5, 0,0, 1,6'd5,4'd0,1,0, 1,4'b0000);
    repeat (2) step(1, 6'd5, 0,0, 1,6'd5,4'd0,0,0, 1,4'b0000);
    step(1, 6'd5, 0,0, 0,0,4'd0,0,0, 0,4'b0000);
    step(1, 6'd5, 0,0, 1,6'd5,4'd0,1,0, 0,4'b0000);
    step(1, 6'd5, 0,0, 0,0,4'd0,0,0, 1,4'b0000);
    repeat (2) step(0, 6'd0, 0,0, 1,6'd5,4'd0,0,0, 0,4'b0000);
    step(1, 6'd5, 0,0, 1,6'd5,4'd0,0,0, 0,4'b0000);
    step(0, 6'd0, 0,0, 1,6'd5,4'd0,1,0, 0,4'b0000);
    step(1, 6'd5, 0,0, 0,0,4'd0,0,0, 0,4'b0000);

    // write index uses w_ghist: idx 3 ^ 0001 -> entry 2 only
    repeat (2) step(0, 6'd0, 0,0, 1,6'd3,4'b0001,1,0, 0,4'b0000);
    step(1, 6'd2, 0,0, 0,0,4'd0,0,0, 1,4'b0000);
    step(1, 6'd3, 0,0, 0,0,4'd0,0,0, 0,4'b0000);
    step(1, 6'd1, 0,0, 0,0,4'd0,0,0, 0,4'b0000);

    // speculative shifts, then restore beating a same-cycle shift
    step(1, 6'd0, 1,1, 0,0,4'd0,0,0, 0,4'b0000);
    step(1, 6'd0, 1,1, 0,0,4'd0,0,0, 0,4'b0001);
    step(1, 6'd0, 1,0, 0,0,4'd0,0,0, 0,4'b0011);
    step(1, 6'd0, 1,0, 1,6'h10,4'b0011,1,1, 0,4'b0110);
    step(1, 6'd5,  0,0, 0,0,4'd0,0,0, 1,4'b0111);
    step(1, 6'h14, 0,0, 0,0,4'd0,0,0, 1,4'b0111);
    step(1, 6'd0, 1,1, 1,6'h3F,4'd0,0,0, 0,4'b0111);
    step(1, 6'd0, 0,0, 0,0,4'd0,0,1, 0,4'b1111);
    step(1, 6'd0, 0,0, 0,0,4'd0,0,0, 0,4'b1111);
    step(1, 6'h0D, 0,0, 0,0,4'd0,0,0, 1,4'b1111);

    // reset mid-operation clears outputs immediately
    clear_inputs();
    reset_i = 0;
    #1;
    chk("rst_op_ready", 32'(ready_o), 0);
    chk("rst_op_pv", 32'(predict_v_o), 0);
    chk("rst_op_pt", 32'(predict_taken_o), 0);
    chk("rst_op_pg", 32'(predict_ghist_o), 0);
    repeat (2) @(negedge clk);

    // reset at init entry 30, sweep must restart from 0
    reset_i = 1;
    repeat (30) @(negedge clk);
    reset_i = 0;
    #1;
    chk("rst_init_ready", 32'(ready_o), 0);
    @(negedge clk);
    init_sweep(1'b1);

    // sweep redefines the table; history cleared, init-time requests ignored
    step(1, 6'd2,  0,0, 0,0,4'd0,0,0, 0,4'b0000);
    step(1, 6'h13, 0,0, 0,0,4'd0,0,0, 0,4'b0000);
    step(1, 6'd5,  0,0, 0,0,4'd0,0,0, 0,4'b0000);
    step(0, 6'd0,  0,0, 0,0,4'd0,0,0, 0,4'b0000);
    step(0, 6'd0,  0,0, 0,0,4'd0,0,0, 0,4'b0000);

    chk("queue_drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
